uart_rx_param: RTL and testbench

- Parametrised successor UART receiver.
- Configurable clock/baud, data width and stop-bit count.
- Mid-bit sampling behind a 2-flop synchroniser, false-start rejection, framing-error detection, and a valid/ready output register with overrun reporting.
- Sits between the board RX pin and the command/byte-stream consumer logic.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_sync.sv | 30 +++
 rtl/uart_rx_param.sv | 219 +++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, defaults and baud helper
package uart_pkg;

  // Receiver FSM states; PARITY is only entered when UART_RX_PARITY_EN is defined
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_e;

  // Board defaults, shared with the transmit side
  localparam int UART_CLK_FREQ = 50000000;
  localparam int UART_BAUD     = 115200;

  // Whole system clocks per line bit (integer divide)
  function automatic int clks_per_bit(input int clk, input int baud);
    return clk / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - 2-flop synchroniser with falling-edge detect, resets to 1
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Resolve metastability, then keep one older sample for edge detection
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver, optional parity via UART_RX_PARITY_EN
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = UART_CLK_FREQ,
  parameter int BAUD      = UART_BAUD,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 RX_IN,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic                 RX_VALID,
  input  logic                 RX_READY,
  output logic                 FRAME_ERR,
  output logic                 PARITY_ERR,
  output logic                 OVERRUN,
  output logic                 BUSY
);

  localparam int CPB  = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CW   = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int HALF = (CPB / 2 > 0) ? CPB / 2 : 1;

  localparam logic [CW-1:0] CNT_FULL  = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(HALF - 1);
  localparam logic [3:0]    BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  logic rx_s;
  logic rx_fall;

  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_now;

  logic                 busy;
  logic                 commit;
  logic                 commit_ferr;

  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 fe_q;
  logic                 pe_q;
  logic                 ovr_q;

  uart_rx_sync u_sync (
    .clk_i   (CLK),
    .rst_i   (RST),
    .async_i (RX_IN),
    .sync_o  (rx_s),
    .fall_o  (rx_fall)
  );

`ifdef UART_RX_PARITY_EN
  logic perr_q, perr_d;
  assign perr_now = perr_q;
`else
  assign perr_now = 1'b0;
`endif

  // FSM state and frame datapath registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  // Next state: half-bit qualify the start bit, then sample every full bit period
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
    perr_d  = perr_q;
`endif
    case (state_q)
      IDLE: begin
        if (rx_fall) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = DATA;
            bit_d   = '0;
            stop_d  = 1'b0;
            ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_d  = 1'b0;
`endif
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 4'd1;
          if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          perr_d  = rx_s ^ (^shift_q) ^ PARITY_ODD;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d  = '0;
          stop_d = stop_q + 1'b1;
          if (!rx_s) begin
            ferr_d = 1'b1;
          end
          if (commit) begin
            state_d = commit_ferr ? WAIT_IDLE : IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_IDLE: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM outputs: busy through the frame body, commit on the last stop sample
  always_comb begin
    busy        = (state_q == DATA) || (state_q == PARITY) || (state_q == STOP);
    commit      = (state_q == STOP) && (cnt_q == CNT_FULL) && (stop_q == STOP_LAST);
    commit_ferr = ferr_q | ~rx_s;
  end

  // Output word register with valid/ready handshake and overrun pulse
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= commit & valid_q & ~RX_READY;
      if (commit) begin
        data_q  <= shift_q;
        fe_q    <= commit_ferr;
        pe_q    <= perr_now;
        valid_q <= 1'b1;
      end else if (RX_READY) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign RX_DATA    = data_q;
  assign RX_VALID   = valid_q;
  assign FRAME_ERR  = fe_q;
  assign PARITY_ERR = pe_q;
  assign OVERRUN    = ovr_q;
  assign BUSY       = busy;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - directed self-checking bench for uart_rx_param
module tb_uart_rx_param;
  import uart_pkg::*;

  localparam int CLKF = 1000000;
  localparam int BR   = 100000;
`ifdef UART_RX_PARITY_EN
  localparam int P7 = 1;
`else
  localparam int P7 = 0;
`endif
  localparam int LAT8 = 8 + 10 * (8 + 1);
  localparam int LAT7 = 8 + 10 * (7 + P7 + 2);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx8 = 1'b1;
  logic rx7 = 1'b1;
  logic rdy8 = 1'b1;
  logic rdy7 = 1'b1;

  logic [7:0] data8;
  logic       valid8, fe8, pe8, ovr8, busy8;
  logic [6:0] data7;
  logic       valid7, fe7, pe7, ovr7, busy7;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int t0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_param #(.CLK_FREQ(CLKF), .BAUD(BR), .DATA_BITS(8), .STOP_BITS(1)) u_dut8 (
    .CLK(clk), .RST(rst), .RX_IN(rx8), .RX_DATA(data8), .RX_VALID(valid8),
    .RX_READY(rdy8), .FRAME_ERR(fe8), .PARITY_ERR(pe8), .OVERRUN(ovr8), .BUSY(busy8)
  );

  uart_rx_param #(.CLK_FREQ(CLKF), .BAUD(BR), .DATA_BITS(7), .STOP_BITS(2)
`ifdef UART_RX_PARITY_EN
    , .PARITY_ODD(1'b0)
`endif
  ) u_dut7 (
    .CLK(clk), .RST(rst), .RX_IN(rx7), .RX_DATA(data7), .RX_VALID(valid7),
    .RX_READY(rdy7), .FRAME_ERR(fe7), .PARITY_ERR(pe7), .OVERRUN(ovr7), .BUSY(busy7)
  );

  // Observation counters sampled on the falling edge
  int   acc8_n = 0, rise8_n = 0, hi8_n = 0, busy8_n = 0, ovr8_n = 0;
  int   rise8_cyc = 0, ovr8_cyc = 0;
  logic v8_prev = 1'b0;
  logic [7:0] acc8_data = '0;
  logic acc8_fe = 1'b0, acc8_pe = 1'b0;

  int   acc7_n = 0, rise7_cyc = 0;
  logic v7_prev = 1'b0;
  logic [6:0] acc7_data = '0;
  logic acc7_fe = 1'b0, acc7_pe = 1'b0;

  always @(negedge clk) begin
    v8_prev <= valid8;
    if (valid8 && !v8_prev) begin
      rise8_n   <= rise8_n + 1;
      rise8_cyc <= cyc;
    end
    if (valid8) hi8_n <= hi8_n + 1;
    if (busy8) busy8_n <= busy8_n + 1;
    if (ovr8) begin
      ovr8_n   <= ovr8_n + 1;
      ovr8_cyc <= cyc;
    end
    if (valid8 && rdy8) begin
      acc8_n    <= acc8_n + 1;
      acc8_data <= data8;
      acc8_fe   <= fe8;
      acc8_pe   <= pe8;
    end
    v7_prev <= valid7;
    if (valid7 && !v7_prev) rise7_cyc <= cyc;
    if (valid7 && rdy7) begin
      acc7_n    <= acc7_n + 1;
      acc7_data <= data7;
      acc7_fe   <= fe7;
      acc7_pe   <= pe7;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive n line bits LSB first, 10 clocks each; caller is aligned #1 after an edge
  task automatic send_bits(input int which, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (which == 0) rx8 = bits[i];
      else rx7 = bits[i];
      wait_cycles(10);
    end
  endtask

  task automatic send_frame8(input logic [7:0] d, input logic stop);
    logic [15:0] fr;
    fr = 16'hFFFF;
    fr[0] = 1'b0;
    fr[8:1] = d;
    fr[9] = stop;
    t0 = cyc;
    send_bits(0, fr, 10);
  endtask

  task automatic send_frame7(input logic [6:0] d, input logic par, input logic stop2);
    logic [15:0] fr;
    int n;
    fr = 16'hFFFF;
    fr[0] = 1'b0;
    fr[7:1] = d;
    n = 8;
    if (P7 == 1) begin
      fr[8] = par;
      n = 9;
    end
    fr[n] = 1'b1;
    fr[n+1] = stop2;
    t0 = cyc;
    send_bits(1, fr, n + 2);
  endtask

  int b_acc, b_rise, b_hi, b_busy, b_ovr, b_acc7;

  initial begin
    // Reset state
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(3);
    check_eq("rst_data", 32'(data8), 32'h0);
    check_eq("rst_valid", 32'(valid8), 32'h0);
    check_eq("rst_ferr", 32'(fe8), 32'h0);
    check_eq("rst_perr", 32'(pe8), 32'h0);
    check_eq("rst_ovr", 32'(ovr8), 32'h0);
    check_eq("rst_busy", 32'(busy8), 32'h0);

    // Clean 0xA5 frame, one stop bit
    b_acc = acc8_n; b_rise = rise8_n; b_hi = hi8_n; b_busy = busy8_n;
    send_frame8(8'hA5, 1'b1);
    wait_cycles(5);
    check_eq("a5_count", 32'(acc8_n - b_acc), 32'd1);
    check_eq("a5_data", 32'(acc8_data), 32'hA5);
    check_eq("a5_ferr", 32'(acc8_fe), 32'h0);
    check_eq("a5_perr", 32'(acc8_pe), 32'h0);
    check_eq("a5_latency", 32'(rise8_cyc - t0), 32'(LAT8));
    check_eq("a5_valid_cycles", 32'(hi8_n - b_hi), 32'd1);
    check_eq("a5_busy_cycles", 32'(busy8_n - b_busy), 32'd90);

    // 3-cycle low glitch is rejected as a false start
    b_acc = acc8_n; b_rise = rise8_n; b_busy = busy8_n;
    rx8 = 1'b0;
    wait_cycles(3);
    rx8 = 1'b1;
    wait_cycles(30);
    check_eq("glitch_no_word", 32'(rise8_n - b_rise), 32'd0);
    check_eq("glitch_no_busy", 32'(busy8_n - b_busy), 32'd0);

    // Low stop bit followed by a break: exactly one errored word
    b_acc = acc8_n;
    send_frame8(8'h3C, 1'b0);
    wait_cycles(40);
    check_eq("brk_count", 32'(acc8_n - b_acc), 32'd1);
    check_eq("brk_data", 32'(acc8_data), 32'h3C);
    check_eq("brk_ferr", 32'(acc8_fe), 32'h1);
    check_eq("brk_state", 32'(u_dut8.state_q), 32'(WAIT_IDLE));
    check_eq("brk_busy", 32'(busy8), 32'h0);
    rx8 = 1'b1;
    wait_cycles(30);
    check_eq("brk_still_one", 32'(acc8_n - b_acc), 32'd1);
    check_eq("brk_idle", 32'(u_dut8.state_q), 32'(IDLE));

    // Back-to-back words with RX_READY low: overrun on the second commit
    rdy8 = 1'b0;
    b_acc = acc8_n; b_rise = rise8_n; b_ovr = ovr8_n;
    send_frame8(8'h11, 1'b1);
    b_hi = t0;
    send_frame8(8'h22, 1'b1);
    wait_cycles(5);
    check_eq("ovr_pulses", 32'(ovr8_n - b_ovr), 32'd1);
    check_eq("ovr_when", 32'(ovr8_cyc - b_hi), 32'(100 + LAT8));
    check_eq("ovr_one_rise", 32'(rise8_n - b_rise), 32'd1);
    check_eq("ovr_data", 32'(data8), 32'h22);
    check_eq("ovr_valid_held", 32'(valid8), 32'h1);
    check_eq("ovr_ferr", 32'(fe8), 32'h0);
    rdy8 = 1'b1;
    @(negedge clk);
    check_eq("ovr_valid_pre_accept", 32'(valid8), 32'h1);
    wait_cycles(1);
    check_eq("ovr_valid_cleared", 32'(valid8), 32'h0);
    check_eq("ovr_accepted", 32'(acc8_n - b_acc), 32'd1);
    check_eq("ovr_accepted_data", 32'(acc8_data), 32'h22);

    // Reset in the middle of data bit 4, then a clean 0xF0
    t0 = cyc;
    send_bits(0, 16'hFF56, 5);
    rx8 = 1'b0;
    wait_cycles(5);
    check_eq("mid_busy_before", 32'(busy8), 32'h1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_data", 32'(data8), 32'h0);
    check_eq("mid_rst_busy", 32'(busy8), 32'h0);
    check_eq("mid_rst_valid", 32'(valid8), 32'h0);
    rx8 = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(5);
    b_acc = acc8_n;
    send_frame8(8'hF0, 1'b1);
    wait_cycles(5);
    check_eq("f0_count", 32'(acc8_n - b_acc), 32'd1);
    check_eq("f0_data", 32'(acc8_data), 32'hF0);
    check_eq("f0_ferr", 32'(acc8_fe), 32'h0);
    check_eq("f0_latency", 32'(rise8_cyc - t0), 32'(LAT8));

    // 7 data bits, 2 stop bits; parity checked when the feature is built in
    b_acc7 = acc7_n;
    send_frame7(7'h55, 1'b1, 1'b1);
    wait_cycles(5);
    check_eq("p_bad_count", 32'(acc7_n - b_acc7), 32'd1);
    check_eq("p_bad_data", 32'(acc7_data), 32'h55);
    check_eq("p_bad_perr", 32'(acc7_pe), 32'(P7));
    check_eq("p_bad_ferr", 32'(acc7_fe), 32'h0);
    check_eq("p_bad_latency", 32'(rise7_cyc - t0), 32'(LAT7));
    send_frame7(7'h55, 1'b0, 1'b1);
    wait_cycles(5);
    check_eq("p_ok_data", 32'(acc7_data), 32'h55);
    check_eq("p_ok_perr", 32'(acc7_pe), 32'h0);
    send_frame7(7'h2A, 1'b1, 1'b0);
    wait_cycles(5);
    rx7 = 1'b1;
    wait_cycles(20);
    check_eq("stop2_count", 32'(acc7_n - b_acc7), 32'd3);
    check_eq("stop2_data", 32'(acc7_data), 32'h2A);
    check_eq("stop2_ferr", 32'(acc7_fe), 32'h1);
    check_eq("stop2_perr", 32'(acc7_pe), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
